fadd_norm_round: RTL and testbench

Back half of the single-precision FP adder pipeline. Accepts the raw post-add fraction, provisional exponent and special-case flags produced after alignment and the fraction add/sub. Normalizes, rounds per the FCSR rounding mode, and packs an IEEE-754 single. It is a two-stage registered pipeline with a valid/ready handshake, so the FPU can stall it without losing results.

---
 rtl/fadd_norm_round_pkg.sv | 49 ++++
 rtl/fadd_norm_round_lzc27.sv | 38 +++
 rtl/fadd_norm_round.sv | 163 ++++++++++++++++
 tb/tb_fadd_norm_round.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_norm_round_pkg.sv
// ---------------------------------------------------------------------------
// fadd_norm_round_pkg
// Shared FPU constants and types for the normalize/round/pack back end of the
// single-precision adder. The rounding-mode encodings match the FCSR field.
//   RM_*        : rounding mode encodings (nearest-even, zero, +inf, -inf)
//   EXP_MAX     : all-ones biased exponent (inf/NaN)
//   MAX_FINITE  : magnitude bits of the largest finite single
//   s1_bundle_t : everything stage 1 hands to stage 2
//   round_inc() : round-up decision from L/G/R/S, mode and sign
// ---------------------------------------------------------------------------
package fadd_norm_round_pkg;

    localparam logic [1:0]  RM_RNE     = 2'd0;
    localparam logic [1:0]  RM_RZ      = 2'd1;
    localparam logic [1:0]  RM_RP      = 2'd2;
    localparam logic [1:0]  RM_RM      = 2'd3;

    localparam logic [7:0]  EXP_MAX    = 8'hFF;
    localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;

    // Normalized significand nf[26:3] plus guard/round/sticky in nf[2:0].
    typedef struct packed {
        logic        sign;
        logic [1:0]  rm;
        logic        is_inf_nan;
        logic [22:0] inf_nan_frac;
        logic [7:0]  ne;
        logic [26:0] nf;
    } s1_bundle_t;

    function automatic logic round_inc(
        input logic [1:0] mode,
        input logic       sgn,
        input logic       l,
        input logic       g,
        input logic       r,
        input logic       s
    );
        logic inc;
        case (mode)
            RM_RNE:  inc = g & (r | s | l);
            RM_RZ:   inc = 1'b0;
            RM_RP:   inc = ~sgn & (g | r | s);
            default: inc = sgn & (g | r | s);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fadd_norm_round_lzc27.sv
// ---------------------------------------------------------------------------
// fp_lzc27
// Combinational leading-zero count over a 27-bit vector. Returns 27 when the
// input is all zero. Shared by the FP adder, multiplier and divider normalizers.
//   din  : vector to scan, bit 26 is the most significant
//   zcnt : number of zeros above the highest set bit (0..27)
// ---------------------------------------------------------------------------
module fp_lzc27 (
    input  logic [26:0] din,
    output logic [4:0]  zcnt
);

    // hit[gi] marks the highest set bit; only one position can be hit.
    logic [26:0] above_zero;
    logic [26:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < 27; gi++) begin : g_scan
            if (gi == 26) begin : g_top
                assign above_zero[gi] = 1'b1;
            end else begin : g_rest
                assign above_zero[gi] = ~|din[26:gi+1];
            end
            assign hit[gi] = din[gi] & above_zero[gi];
        end
    endgenerate

    always_comb begin
        zcnt = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (hit[i]) begin
                zcnt = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fadd_norm_round.sv
// ---------------------------------------------------------------------------
// fadd_norm_round
// Back half of the single-precision FP adder: normalizes the raw post-add
// fraction (stage 1), rounds per the rounding mode and packs an IEEE-754
// single (stage 2). Two registered stages with a valid/ready handshake.
//   clk, clrn      : clock, asynchronous active-low reset
//   in_valid/ready : input handshake (transfer on in_valid & in_ready)
//   rm             : rounding mode (RNE, RZ, RP, RM)
//   is_inf_nan     : either operand was inf/NaN; inf_nan_frac is emitted
//   sign           : result sign
//   temp_exp       : larger operand's biased exponent
//   cal_frac       : [27] carry, [26:3] significand, [2:0] guard/round/sticky
//   out_valid/ready: output handshake (transfer on out_valid & out_ready)
//   s              : packed result, ovf: finite overflow occurred
// ---------------------------------------------------------------------------
module fadd_norm_round
    import fadd_norm_round_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  rm,
    input  logic        is_inf_nan,
    input  logic [22:0] inf_nan_frac,
    input  logic        sign,
    input  logic [7:0]  temp_exp,
    input  logic [27:0] cal_frac,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic        ovf
);

    logic        s1_valid_reg;
    logic        out_valid_reg;
    s1_bundle_t  s1_reg;
    s1_bundle_t  s1_next;
    logic [31:0] s_reg;
    logic [31:0] s_next;
    logic        ovf_reg;
    logic        ovf_next;

    // Handshake: stage 2 moves when its output slot is free or being taken;
    // stage 1 moves when empty or when stage 2 moves. No path from in_valid.
    logic s2_adv;
    logic s1_adv;
    logic in_fire;
    logic s2_fire;

    assign s2_adv  = ~out_valid_reg | out_ready;
    assign s1_adv  = ~s1_valid_reg | s2_adv;
    assign in_fire = in_valid & s1_adv;
    assign s2_fire = s1_valid_reg & s2_adv;

    assign in_ready  = s1_adv;
    assign out_valid = out_valid_reg;
    assign s         = s_reg;
    assign ovf       = ovf_reg;

    // ---------------- stage 1: normalize ----------------
    logic [4:0] lz;
    logic [7:0] den_shift;

    fp_lzc27 u_lzc (
        .din  (cal_frac[26:0]),
        .zcnt (lz)
    );

    // A denormal result can only shift up until the exponent reaches 1.
    assign den_shift = (temp_exp == 8'd0) ? 8'd0 : temp_exp - 8'd1;

    always_comb begin
        s1_next              = '0;
        s1_next.sign         = sign;
        s1_next.rm           = rm;
        s1_next.is_inf_nan   = is_inf_nan;
        s1_next.inf_nan_frac = inf_nan_frac;
        if (cal_frac == 28'd0) begin
            s1_next.nf = 27'd0;
            s1_next.ne = 8'd0;
        end else if (cal_frac[27]) begin
            // Carry out: shift right one, folding the dropped bit into sticky.
            s1_next.nf = {cal_frac[27:2], cal_frac[1] | cal_frac[0]};
            s1_next.ne = temp_exp + 8'd1;
        end else if (temp_exp > {3'b000, lz}) begin
            s1_next.nf = cal_frac[26:0] << lz;
            s1_next.ne = temp_exp - {3'b000, lz};
        end else begin
            s1_next.nf = cal_frac[26:0] << den_shift;
            s1_next.ne = 8'd0;
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic        inc;
    logic [24:0] m;
    logic [8:0]  exp_sum;
    logic [22:0] frac;
    logic        to_inf;

    assign inc = round_inc(s1_reg.rm, s1_reg.sign,
                           s1_reg.nf[3], s1_reg.nf[2], s1_reg.nf[1], s1_reg.nf[0]);
    assign m   = {1'b0, s1_reg.nf[26:3]} + {24'd0, inc};

    // Rounding carry bumps the exponent; a denormal that rounds up into the
    // hidden-bit position becomes the smallest normal (exponent 1).
    always_comb begin
        exp_sum = {1'b0, s1_reg.ne};
        frac    = m[22:0];
        if (m[24]) begin
            exp_sum = {1'b0, s1_reg.ne} + 9'd1;
            frac    = m[23:1];
        end else if ((s1_reg.ne == 8'd0) && m[23]) begin
            exp_sum = 9'd1;
        end
    end

    assign to_inf = (s1_reg.rm == RM_RNE) |
                    ((s1_reg.rm == RM_RP) & ~s1_reg.sign) |
                    ((s1_reg.rm == RM_RM) &  s1_reg.sign);

    always_comb begin
        s_next   = {s1_reg.sign, exp_sum[7:0], frac};
        ovf_next = 1'b0;
        if (s1_reg.is_inf_nan) begin
            s_next = {s1_reg.sign, EXP_MAX, s1_reg.inf_nan_frac};
        end else if (exp_sum >= {1'b0, EXP_MAX}) begin
            ovf_next = 1'b1;
            s_next   = to_inf ? {s1_reg.sign, EXP_MAX, 23'd0}
                              : {s1_reg.sign, MAX_FINITE};
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            s_reg         <= 32'd0;
            ovf_reg       <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
            end
            if (s2_adv) begin
                out_valid_reg <= s1_valid_reg;
            end
            if (s2_fire) begin
                s_reg   <= s_next;
                ovf_reg <= ovf_next;
            end
        end
    end

    // Stage-1 payload is qualified by s1_valid_reg, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_reg <= s1_next;
        end
    end

endmodule

// File: tb/tb_fadd_norm_round.sv
module tb_fadd_norm_round;

    logic        clk = 1'b0;
    logic        clrn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  rm;
    logic        is_inf_nan;
    logic [22:0] inf_nan_frac;
    logic        sign;
    logic [7:0]  temp_exp;
    logic [27:0] cal_frac;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        ovf;

    always #5 clk = ~clk;

    fadd_norm_round dut (
        .clk          (clk),
        .clrn         (clrn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rm           (rm),
        .is_inf_nan   (is_inf_nan),
        .inf_nan_frac (inf_nan_frac),
        .sign         (sign),
        .temp_exp     (temp_exp),
        .cal_frac     (cal_frac),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .s            (s),
        .ovf          (ovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Reference: value-level normalize then integer rounding of the 24-bit
    // significand with a 3-bit remainder. Returns {ovf, s}.
    function automatic logic [32:0] ref_model(input logic sg, input logic [1:0] rmv,
                                              input logic [7:0] te, input logic [27:0] cf,
                                              input logic inf, input logic [22:0] nfr);
        logic [26:0] nf;
        int          e;
        int          z;
        int unsigned mant;
        int          rem;
        bit          up;
        bit          to_inf;
        logic [31:0] ev;
        if (inf) return {1'b0, sg, 8'hFF, nfr};
        if (cf == 28'd0) begin
            nf = 27'd0;
            e  = 0;
        end else if (cf[27]) begin
            nf    = cf[27:1];
            nf[0] = nf[0] | cf[0];
            e     = int'(te) + 1;
        end else begin
            z = 0;
            while (z < 27 && cf[26-z] == 1'b0) z++;
            if (int'(te) > z) begin
                nf = 27'(cf[26:0] << z);
                e  = int'(te) - z;
            end else begin
                nf = 27'(cf[26:0] << ((te == 8'd0) ? 0 : int'(te) - 1));
                e  = 0;
            end
        end
        mant = 32'(nf[26:3]);
        rem  = int'(nf[2:0]);
        case (rmv)
            2'd0:    up = (rem > 4) || (rem == 4 && mant[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = !sg && rem != 0;
            default: up = sg && rem != 0;
        endcase
        if (up) mant = mant + 1;
        if (mant >= 32'h0100_0000) begin
            mant = mant >> 1;
            e    = e + 1;
        end else if (e == 0 && mant >= 32'h0080_0000) begin
            e = 1;
        end
        if (e >= 255) begin
            to_inf = (rmv == 2'd0) || (rmv == 2'd2 && !sg) || (rmv == 2'd3 && sg);
            return to_inf ? {1'b1, sg, 8'hFF, 23'd0} : {1'b1, sg, 31'h7F7FFFFF};
        end
        ev = 32'(e);
        return {1'b0, sg, ev[7:0], mant[22:0]};
    endfunction

    typedef struct {
        logic        sg;
        logic [1:0]  rmv;
        logic [7:0]  te;
        logic [27:0] cf;
        logic        inf;
        logic [22:0] nfr;
        logic [31:0] es;
        logic        eo;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(input logic sg, input logic [1:0] rmv, input logic [7:0] te,
                                input logic [27:0] cf, input logic inf, input logic [22:0] nfr,
                                input logic [31:0] es, input logic eo);
        vec_t v;
        v.sg = sg; v.rmv = rmv; v.te = te; v.cf = cf; v.inf = inf; v.nfr = nfr;
        v.es = es; v.eo = eo;
        return v;
    endfunction

    task automatic drive(input logic sg, input logic [1:0] rmv, input logic [7:0] te,
                         input logic [27:0] cf, input logic inf, input logic [22:0] nfr);
        sign = sg; rm = rmv; temp_exp = te; cal_frac = cf; is_inf_nan = inf; inf_nan_frac = nfr;
    endtask

    // One transfer with free output: checks acceptance, 2-cycle latency, result.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.sg, v.rmv, v.te, v.cf, v.inf, v.nfr);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d_early_valid", idx), {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk($sformatf("vec%0d_valid", idx), {31'd0, out_valid}, 32'd1);
        chk($sformatf("vec%0d_s", idx), s, v.es);
        chk($sformatf("vec%0d_ovf", idx), {31'd0, ovf}, {31'd0, v.eo});
        $display("vec%0d te=%h cf=%h rm=%0d sg=%0d -> s=%h ovf=%0d", idx, v.te, v.cf, v.rmv, v.sg, s, ovf);
    endtask

    task automatic rand_inputs();
        logic [27:0] r;
        sign         = 1'($urandom);
        rm           = 2'($urandom);
        is_inf_nan   = ($urandom_range(0, 15) == 0);
        inf_nan_frac = 23'($urandom);
        case ($urandom_range(0, 3))
            0:       temp_exp = 8'($urandom_range(0, 254));
            1:       temp_exp = 8'($urandom_range(0, 30));
            2:       temp_exp = 8'($urandom_range(240, 254));
            default: temp_exp = 8'($urandom_range(100, 140));
        endcase
        r = 28'($urandom);
        case ($urandom_range(0, 3))
            0:       cal_frac = r;
            1:       cal_frac = r >> $urandom_range(0, 27);
            2:       cal_frac = {1'b1, r[26:0]};
            default: cal_frac = {4'b0111, r[23:0]};
        endcase
    endtask

    logic [32:0] sbq[$];
    bit          stall_prev = 1'b0;
    logic [31:0] s_prev;
    logic        ovf_prev;
    int          n_sent = 0;
    int          n_recv = 0;

    // One clock of streaming with scoreboard and stall-stability checks.
    task automatic step(input bit iv, input bit ordy);
        logic [32:0] e;
        @(negedge clk);
        if (stall_prev) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_s", s, s_prev);
            chk("stall_ovf", {31'd0, ovf}, {31'd0, ovf_prev});
        end
        rand_inputs();
        in_valid  = iv;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got s=%h want no result pending", s);
            end else begin
                e = sbq.pop_front();
                chk("stream_s", s, e[31:0]);
                chk("stream_ovf", {31'd0, ovf}, {31'd0, e[32]});
                n_recv++;
                $display("out s=%h ovf=%0d want s=%h ovf=%0d", s, ovf, e[31:0], e[32]);
            end
        end
        if (in_valid && in_ready) begin
            sbq.push_back(ref_model(sign, rm, temp_exp, cal_frac, is_inf_nan, inf_nan_frac));
            n_sent++;
        end
        stall_prev = out_valid && !out_ready;
        s_prev     = s;
        ovf_prev   = ovf;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        clrn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_s", s, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        n_sent     = n_sent - sbq.size();
        sbq.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        $display("mid-stream reset applied, in-flight results discarded");
    endtask

    initial begin
        clrn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'd0, 8'd0, 28'd0, 1'b0, 23'd0);

        vt[0]  = mk(0, 0, 8'h7F, 28'h8000000, 0, 23'h0, 32'h40000000, 0);
        vt[1]  = mk(0, 0, 8'h7F, 28'h0000008, 0, 23'h0, 32'h34000000, 0);
        vt[2]  = mk(1, 0, 8'h7F, 28'h0000000, 0, 23'h0, 32'h80000000, 0);
        vt[3]  = mk(0, 0, 8'h7F, 28'h4000004, 0, 23'h0, 32'h3F800000, 0);
        vt[4]  = mk(0, 0, 8'h7F, 28'h400000C, 0, 23'h0, 32'h3F800002, 0);
        vt[5]  = mk(1, 2, 8'h7F, 28'h4000004, 0, 23'h0, 32'hBF800000, 0);
        vt[6]  = mk(1, 3, 8'h7F, 28'h4000004, 0, 23'h0, 32'hBF800001, 0);
        vt[7]  = mk(0, 0, 8'hFE, 28'hFFFFFF8, 0, 23'h0, 32'h7F800000, 1);
        vt[8]  = mk(0, 1, 8'hFE, 28'hFFFFFF8, 0, 23'h0, 32'h7F7FFFFF, 1);
        vt[9]  = mk(0, 3, 8'hFE, 28'hFFFFFF8, 0, 23'h0, 32'h7F7FFFFF, 1);
        vt[10] = mk(1, 3, 8'hFE, 28'hFFFFFF8, 0, 23'h0, 32'hFF800000, 1);
        vt[11] = mk(0, 3, 8'h12, 28'h1234567, 1, 23'h400000, 32'h7FC00000, 0);
        vt[12] = mk(0, 0, 8'h01, 28'h2000000, 0, 23'h0, 32'h00400000, 0);
        vt[13] = mk(0, 0, 8'h01, 28'h3FFFFFC, 0, 23'h0, 32'h00800000, 0);
        vt[14] = mk(0, 0, 8'h7F, 28'h7FFFFFC, 0, 23'h0, 32'h40000000, 0);
        vt[15] = mk(0, 2, 8'h7F, 28'h8000001, 0, 23'h0, 32'h40000001, 0);
        vt[16] = mk(0, 0, 8'h00, 28'h0000010, 0, 23'h0, 32'h00000002, 0);

        repeat (2) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_s", s, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        clrn = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(vt[i], i);

        // Stream, stall, stream, stall again and reset mid-stall.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        mid_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        chk("handshake_count", 32'(n_recv), 32'(n_sent));

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 50 && (sbq.size() != 0 || out_valid); i++) step(1'b0, 1'b1);
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        chk("sent_vs_recv", 32'(n_recv), 32'(n_sent));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
